smp_resv_arb: RTL and testbench
===============================

SMP_RESV_ARB -- requirements
Module: smp_resv_arb

Interface
REQ-001 SHALL have parameter RA_W, default 27, reservation-granule address width (real address bits 31:5, 32B granule).
REQ-002 SHALL have parameter NT, default 4, thread count; only NT=4 is supported.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1, sole clock; all state rising-edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 4, per-thread request valid.
REQ-007 SHALL have port req_op, input, 8, 2b op per thread t at [2t+1:2t]: 01 larx, 10 stcx, 11 store, 00 reserved.
REQ-008 SHALL have port req_ra, input, 4*RA_W, granule address per thread t at [RA_W*t +: RA_W].
REQ-009 SHALL have port req_ready, output, 4, grant; at most one bit set per cycle.
REQ-010 SHALL have port snp_valid, input, 1, external store/invalidate snoop from another core.
REQ-011 SHALL have port snp_ra, input, RA_W, snoop granule address.
REQ-012 SHALL have port kill, input, 4, per-thread reservation clear (interrupt/context sync).
REQ-013 SHALL have port rsp_valid, output, 1, stcx result valid.
REQ-014 SHALL have port rsp_tid, output, 2, thread of stcx result.
REQ-015 SHALL have port rsp_pass, output, 1, 1 = stcx succeeded.
REQ-016 SHALL have port resv_v, output, 4, per-thread reservation valid status.

Function
REQ-017 SHALL hold per thread a reservation register {v, ra[RA_W-1:0]}.
REQ-018 SHALL grant one valid requester per cycle, round-robin; priority starts at thread after last grant; after reset thread 0 highest.
REQ-019 SHALL drive req_ready combinationally in the same cycle; transfer occurs when req_valid & req_ready; requester holds op/ra stable until transfer.
REQ-020 SHALL, per cycle, apply in order: snoop clear, kill, then granted op; all effects registered at the next edge.
REQ-021 Snoop: SHALL clear v of every thread whose v=1 and ra==snp_ra.
REQ-022 Kill: SHALL clear v of each thread t with kill[t]=1.
REQ-023 larx by t: SHALL set v=1, ra=req_ra for t, overriding same-cycle snoop/kill of t.
REQ-024 stcx by t: pass = v(after snoop/kill) & ra==req_ra; SHALL clear t's v regardless; on pass SHALL also clear matching reservations of all other threads.
REQ-025 store by t: SHALL clear matching reservations of all threads other than t; t's own reservation unchanged.
REQ-026 op 00 SHALL be granted and consumed with no state change and no response.
REQ-027 SHALL assert rsp_valid exactly one cycle after each stcx transfer, for one cycle, with rsp_tid and rsp_pass registered.
REQ-028 Latency: larx reservation visible on resv_v one cycle after transfer; back-to-back transfers each cycle SHALL be sustained.

Reset
REQ-029 On rst: all v=0, ra=0, resv_v=0, rsp_valid=0, rsp_tid=0, rsp_pass=0, RR pointer=thread 0 highest.
REQ-030 req_ready SHALL be 0 while rst is asserted; an in-flight stcx response SHALL be dropped.

Structure
REQ-031 Op encodings and RA_W default SHALL live in shared package smp_pkg.
REQ-032 The round-robin grant SHALL be sub-module rr_arb4 (req[3:0], grant[3:0], pointer update on transfer).

Verification
REQ-033 Larx t1 ra=0x0000123, then stcx t1 ra=0x0000123 -> rsp_valid next cycle, rsp_tid=1, rsp_pass=1, resv_v[1]=0.
REQ-034 Larx t0 ra=0x0000040; snp_valid ra=0x0000040 in same cycle as stcx t0 ra=0x0000040 -> rsp_pass=0.
REQ-035 Larx t0 and t2 both ra=0x0000AAA; store t3 ra=0x0000AAA -> resv_v=0000; stcx t2 afterwards -> rsp_pass=0.
REQ-036 All four threads req_valid=1 continuously from reset -> grants 0,1,2,3,0 on consecutive cycles.
REQ-037 Larx t2 ra=0x0000005 with kill[2]=1 same cycle -> resv_v[2]=1; kill[2] next cycle alone -> resv_v[2]=0.
REQ-038 Assert rst one cycle after stcx transfer -> rsp_valid stays 0, resv_v=0000, next grant to thread 0.

Source files
------------

// File: rtl/smp_pkg.sv
// -----------------------------------------------------------------------------
// smp_pkg
// Shared definitions for the SMP reservation arbiter: request op encodings,
// default reservation-granule address width, thread count, and a one-hot to
// index helper used by the arbiter and the reservation datapath.
// -----------------------------------------------------------------------------
package smp_pkg;

  // Granule address is real address bits 31:5 (32-byte reservation granule).
  localparam int RA_W_DEF = 27;
  localparam int NT_DEF   = 4;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,  // reserved: consumed, no effect
    OP_LARX  = 2'b01,
    OP_STCX  = 2'b10,
    OP_STORE = 2'b11
  } op_e;

  function automatic logic [1:0] oh_to_idx(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// -----------------------------------------------------------------------------
// rr_arb4
// Four-way round-robin arbiter. The thread after the last granted one has
// highest priority; after reset thread 0 is highest. Grant is combinational
// and forced low while rst is asserted.
//   clk, rst   : clock, asynchronous active-high reset
//   req[3:0]   : request vector
//   grant[3:0] : one-hot grant (or zero), a grant is always a transfer
// -----------------------------------------------------------------------------
module rr_arb4
  import smp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant
);

  logic [1:0] ptr_q;  // index of the highest-priority thread this cycle

  // NOTE: every output of an always_comb gets a default on entry so no path
  // leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    grant = '0;
    found = 1'b0;
    idx   = ptr_q;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        idx = ptr_q + 2'(k);
        if (req[idx] && !found) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr_q <= 2'd0;
    else if (|grant)  ptr_q <= oh_to_idx(grant) + 2'd1;
  end

endmodule

// File: rtl/smp_resv_arb.sv
// -----------------------------------------------------------------------------
// smp_resv_arb
// Per-thread larx/stcx reservation tracking for a 4-thread SMP core with a
// round-robin request port, external snoop invalidation and per-thread kill.
// Each cycle the effects apply in order: snoop clear, kill, granted op.
//   clk, rst          : clock, asynchronous active-high reset
//   req_valid[3:0]    : per-thread request valid
//   req_op[7:0]       : 2-bit op per thread at [2t+1:2t]
//   req_ra[4*RA_W-1:0]: granule address per thread at [RA_W*t +: RA_W]
//   req_ready[3:0]    : combinational one-hot grant
//   snp_valid, snp_ra : snoop from another core, clears matching reservations
//   kill[3:0]         : per-thread reservation clear
//   rsp_valid/tid/pass: registered stcx result, one cycle after transfer
//   resv_v[3:0]       : per-thread reservation valid
// -----------------------------------------------------------------------------
module smp_resv_arb
  import smp_pkg::*;
#(
  parameter int RA_W = RA_W_DEF,
  parameter int NT   = NT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NT-1:0]     req_valid,
  input  logic [2*NT-1:0]   req_op,
  input  logic [NT*RA_W-1:0] req_ra,
  output logic [NT-1:0]     req_ready,
  input  logic              snp_valid,
  input  logic [RA_W-1:0]   snp_ra,
  input  logic [NT-1:0]     kill,
  output logic              rsp_valid,
  output logic [1:0]        rsp_tid,
  output logic              rsp_pass,
  output logic [NT-1:0]     resv_v
);

  logic [NT-1:0]   v_q, v_d;
  logic [RA_W-1:0] ra_q [NT];
  logic [RA_W-1:0] ra_d [NT];
  logic [RA_W-1:0] ra_in [NT];
  op_e             op_in [NT];

  logic [1:0]      gidx;
  op_e             gop;
  logic [RA_W-1:0] gra;
  logic            rsp_fire;
  logic            pass_d;

  rr_arb4 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .grant (req_ready)
  );

  for (genvar t = 0; t < NT; t++) begin : g_unpack
    assign ra_in[t] = req_ra[RA_W*t +: RA_W];
    assign op_in[t] = op_e'(req_op[2*t +: 2]);
  end

  assign gidx = oh_to_idx(req_ready);
  assign gop  = op_in[gidx];
  assign gra  = ra_in[gidx];

  always_comb begin
    v_d      = v_q;
    ra_d     = ra_q;
    rsp_fire = 1'b0;
    pass_d   = 1'b0;

    for (int t = 0; t < NT; t++) begin
      if (snp_valid && v_q[t] && (ra_q[t] == snp_ra)) v_d[t] = 1'b0;
      if (kill[t])                                    v_d[t] = 1'b0;
    end

    if (|req_ready) begin
      unique case (gop)
        OP_LARX: begin
          // Wins over a same-cycle snoop/kill of the same thread.
          v_d[gidx]  = 1'b1;
          ra_d[gidx] = gra;
        end
        OP_STCX: begin
          rsp_fire  = 1'b1;
          pass_d    = v_d[gidx] && (ra_q[gidx] == gra);
          v_d[gidx] = 1'b0;
          if (pass_d) begin
            for (int t = 0; t < NT; t++)
              if ((2'(t) != gidx) && (ra_q[t] == gra)) v_d[t] = 1'b0;
          end
        end
        OP_STORE: begin
          // Own reservation survives its own store.
          for (int t = 0; t < NT; t++)
            if ((2'(t) != gidx) && (ra_q[t] == gra)) v_d[t] = 1'b0;
        end
        OP_NOP: ;
      endcase
    end
  end

  // NOTE: the reservation address array is reset too, so resv state never
  // carries X into address compares after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q       <= '0;
      for (int t = 0; t < NT; t++) ra_q[t] <= '0;
      rsp_valid <= 1'b0;
      rsp_tid   <= 2'd0;
      rsp_pass  <= 1'b0;
    end else begin
      v_q       <= v_d;
      ra_q      <= ra_d;
      rsp_valid <= rsp_fire;
      if (rsp_fire) begin
        rsp_tid  <= gidx;
        rsp_pass <= pass_d;
      end
    end
  end

  assign resv_v = v_q;

endmodule

// File: tb/tb_smp_resv_arb.sv
// -----------------------------------------------------------------------------
// tb_smp_resv_arb
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural reservation model held in plain arrays.
// -----------------------------------------------------------------------------
module tb_smp_resv_arb;
  import smp_pkg::*;

  localparam int RA_W = 27;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        req_valid;
  logic [7:0]        req_op;
  logic [4*RA_W-1:0] req_ra;
  logic [3:0]        req_ready;
  logic              snp_valid;
  logic [RA_W-1:0]   snp_ra;
  logic [3:0]        kill;
  logic              rsp_valid;
  logic [1:0]        rsp_tid;
  logic              rsp_pass;
  logic [3:0]        resv_v;

  smp_resv_arb #(.RA_W(RA_W), .NT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_ra    (req_ra),
    .req_ready (req_ready),
    .snp_valid (snp_valid),
    .snp_ra    (snp_ra),
    .kill      (kill),
    .rsp_valid (rsp_valid),
    .rsp_tid   (rsp_tid),
    .rsp_pass  (rsp_pass),
    .resv_v    (resv_v)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  bit              m_v  [4];
  logic [RA_W-1:0] m_ra [4];
  int              m_next;      // thread that gets first look next cycle
  bit              m_rv;
  int              m_tid;
  bit              m_pass;

  task automatic model_reset();
    for (int t = 0; t < 4; t++) begin m_v[t] = 0; m_ra[t] = '0; end
    m_next = 0; m_rv = 0; m_tid = 0; m_pass = 0;
  endtask

  function automatic int exp_grant(input logic [3:0] val);
    for (int k = 0; k < 4; k++)
      if (val[(m_next + k) % 4]) return (m_next + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] m_resv();
    logic [3:0] r;
    for (int t = 0; t < 4; t++) r[t] = m_v[t];
    return r;
  endfunction

  task automatic model_step(input logic [7:0] op, input logic [4*RA_W-1:0] ra,
                            input logic sv, input logic [RA_W-1:0] sra,
                            input logic [3:0] kl, input int g);
    bit              nv [4];
    logic [1:0]      o;
    logic [RA_W-1:0] a;
    bit              ok;
    for (int t = 0; t < 4; t++) begin
      nv[t] = m_v[t];
      if (sv && m_v[t] && m_ra[t] == sra) nv[t] = 0;
      if (kl[t]) nv[t] = 0;
    end
    m_rv = 0;
    if (g >= 0) begin
      m_next = (g + 1) % 4;
      o = op[2*g +: 2];
      a = ra[RA_W*g +: RA_W];
      if (o == 2'b01) begin
        nv[g] = 1; m_ra[g] = a;
      end else if (o == 2'b10) begin
        ok = nv[g] && (m_ra[g] == a);
        nv[g] = 0;
        if (ok) for (int t = 0; t < 4; t++) if (t != g && m_ra[t] == a) nv[t] = 0;
        m_rv = 1; m_tid = g; m_pass = ok;
      end else if (o == 2'b11) begin
        for (int t = 0; t < 4; t++) if (t != g && m_ra[t] == a) nv[t] = 0;
      end
    end
    for (int t = 0; t < 4; t++) m_v[t] = nv[t];
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [7:0] mk_op(input int t, input logic [1:0] o);
    logic [7:0] r;
    r = '0; r[2*t +: 2] = o;
    return r;
  endfunction

  function automatic logic [4*RA_W-1:0] mk_ra(input int t, input logic [RA_W-1:0] a);
    logic [4*RA_W-1:0] r;
    r = '0; r[RA_W*t +: RA_W] = a;
    return r;
  endfunction

  // Called just after a rising edge: drive, check grant, clock, check state.
  task automatic cycle(input logic [3:0] val, input logic [7:0] op,
                       input logic [4*RA_W-1:0] ra, input logic sv,
                       input logic [RA_W-1:0] sra, input logic [3:0] kl,
                       output int g);
    req_valid = val; req_op = op; req_ra = ra;
    snp_valid = sv; snp_ra = sra; kill = kl;
    #1;
    g = exp_grant(val);
    check("grant", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    @(posedge clk);
    model_step(op, ra, sv, sra, kl, g);
    #1;
    check("resv_v", 32'(resv_v), 32'(m_resv()));
    check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    if (m_rv) begin
      check("rsp_tid", 32'(rsp_tid), 32'(m_tid));
      check("rsp_pass", 32'(rsp_pass), 32'(m_pass));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'hF; req_op = '0; req_ra = '0;
    snp_valid = 1'b0; snp_ra = '0; kill = '0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_resv_v", 32'(resv_v), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_tid", 32'(rsp_tid), 32'd0);
    check("rst_rsp_pass", 32'(rsp_pass), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = '0;
    model_reset();
  endtask

  logic [RA_W-1:0] pool [4];
  bit              pv [4];
  logic [1:0]      po [4];
  logic [RA_W-1:0] pa [4];

  initial begin
    int g;
    int exp_seq [5];
    logic [3:0]        val;
    logic [7:0]        op;
    logic [4*RA_W-1:0] ra;
    int r;

    pool[0] = 27'h0000123; pool[1] = 27'h0000040;
    pool[2] = 27'h0000AAA; pool[3] = 27'h7FFFFFF;
    exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 2; exp_seq[3] = 3; exp_seq[4] = 0;

    do_reset();

    // Round-robin from reset with everyone requesting (op 00: no side effects).
    for (int i = 0; i < 5; i++) begin
      cycle(4'hF, 8'h00, '0, 1'b0, '0, 4'h0, g);
      check("rr_seq", 32'(g), 32'(exp_seq[i]));
    end

    // larx/stcx pass on thread 1.
    cycle(4'b0010, mk_op(1, OP_LARX), mk_ra(1, 27'h123), 1'b0, '0, 4'h0, g);
    check("larx_visible", 32'(resv_v[1]), 32'd1);
    cycle(4'b0010, mk_op(1, OP_STCX), mk_ra(1, 27'h123), 1'b0, '0, 4'h0, g);
    check("stcx_pass_valid", 32'(rsp_valid), 32'd1);
    check("stcx_pass_tid", 32'(rsp_tid), 32'd1);
    check("stcx_pass", 32'(rsp_pass), 32'd1);
    check("stcx_clears_own", 32'(resv_v[1]), 32'd0);

    // Snoop in the same cycle as stcx kills the reservation first.
    cycle(4'b0001, mk_op(0, OP_LARX), mk_ra(0, 27'h40), 1'b0, '0, 4'h0, g);
    cycle(4'b0001, mk_op(0, OP_STCX), mk_ra(0, 27'h40), 1'b1, 27'h40, 4'h0, g);
    check("snoop_stcx_pass", 32'(rsp_pass), 32'd0);

    // Store from another thread clears all matching reservations.
    cycle(4'b0001, mk_op(0, OP_LARX), mk_ra(0, 27'hAAA), 1'b0, '0, 4'h0, g);
    cycle(4'b0100, mk_op(2, OP_LARX), mk_ra(2, 27'hAAA), 1'b0, '0, 4'h0, g);
    check("two_resv", 32'(resv_v), 32'b0101);
    cycle(4'b1000, mk_op(3, OP_STORE), mk_ra(3, 27'hAAA), 1'b0, '0, 4'h0, g);
    check("store_clear", 32'(resv_v), 32'd0);
    cycle(4'b0100, mk_op(2, OP_STCX), mk_ra(2, 27'hAAA), 1'b0, '0, 4'h0, g);
    check("store_stcx_pass", 32'(rsp_pass), 32'd0);

    // larx overrides same-cycle kill; kill alone clears.
    cycle(4'b0100, mk_op(2, OP_LARX), mk_ra(2, 27'h5), 1'b0, '0, 4'b0100, g);
    check("larx_over_kill", 32'(resv_v[2]), 32'd1);
    cycle(4'b0000, 8'h00, '0, 1'b0, '0, 4'b0100, g);
    check("kill_alone", 32'(resv_v[2]), 32'd0);

    // Reset right after an stcx transfer drops the response.
    cycle(4'b0001, mk_op(0, OP_LARX), mk_ra(0, 27'h40), 1'b0, '0, 4'h0, g);
    req_valid = 4'b0001; req_op = mk_op(0, OP_STCX); req_ra = mk_ra(0, 27'h40);
    #1;
    check("pre_rst_grant", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    do_reset();
    cycle(4'hF, 8'h00, '0, 1'b0, '0, 4'h0, g);
    check("post_rst_grant", 32'(g), 32'd0);

    // Randomized traffic; requesters hold op/ra until granted.
    for (int t = 0; t < 4; t++) pv[t] = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(149) == 0) begin
        do_reset();
        for (int t = 0; t < 4; t++) pv[t] = 0;
      end else begin
        for (int t = 0; t < 4; t++) begin
          if (!pv[t] && $urandom_range(2) == 0) begin
            r = $urandom_range(7);
            pv[t] = 1;
            po[t] = (r < 3) ? 2'b01 : (r < 5) ? 2'b10 : (r < 7) ? 2'b11 : 2'b00;
            pa[t] = pool[$urandom_range(3)];
          end
        end
        val = '0; op = '0; ra = '0;
        for (int t = 0; t < 4; t++) begin
          val[t] = pv[t];
          op[2*t +: 2] = po[t];
          ra[RA_W*t +: RA_W] = pa[t];
        end
        cycle(val, op, ra, ($urandom_range(3) == 0), pool[$urandom_range(3)],
              {($urandom_range(7) == 0), ($urandom_range(7) == 0),
               ($urandom_range(7) == 0), ($urandom_range(7) == 0)}, g);
        if (g >= 0) pv[g] = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
